// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_skid
//  Purpose  : Parametrised pipeline stage register with a valid/ready
//             handshake and a 2-entry skid buffer. Upstream ready is
//             driven purely from registered state. Supports flush (bubble
//             insertion) and a saturating count of bubble cycles seen
//             downstream.
//  Ports    : clk, rst          - clock (rising edge), sync active-high reset
//             flush             - discard all held and incoming entries
//             in_valid/in_ready - upstream handshake (in_ready registered)
//             in_ctrl/in_data   - upstream control and data words
//             out_valid/out_ready - downstream handshake
//             out_ctrl/out_data - main entry (ctrl all-zero during bubbles)
//             occupancy         - entries held (0..2)
//             bubble_cnt        - saturating count of bubble cycles
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
  parameter int CTRL_W     = 23,
  parameter int DATA_W     = 64,
  parameter bit CLEAR_DATA = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic acc;
  logic con;

  // The skid slot being empty is the only condition for accepting, so
  // in_ready never depends on out_ready within the same cycle.
  assign in_ready  = ~skid_valid;
  assign acc       = in_valid & in_ready & ~flush;
  assign con       = main_valid & out_ready;

  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      bubble_cnt <= '0;
    end else begin
      // A bubble is a cycle where downstream could take an entry but none
      // is offered; flush cycles count too.
      if (out_ready && !main_valid && bubble_cnt != CNT_MAX) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end

      if (flush) begin
        main_valid <= 1'b0;
        main_ctrl  <= '0;
        skid_valid <= 1'b0;
        skid_ctrl  <= '0;
        if (CLEAR_DATA) begin
          main_data <= '0;
          skid_data <= '0;
        end
      end else if (skid_valid) begin
        // FULL: in_ready is low, so only a drain can happen.
        if (con) begin
          main_ctrl  <= skid_ctrl;
          main_data  <= skid_data;
          skid_valid <= 1'b0;
          skid_ctrl  <= '0;
        end
      end else if (main_valid) begin
        // ONE
        if (acc && con) begin
          main_ctrl <= in_ctrl;
          main_data <= in_data;
        end else if (acc) begin
          skid_valid <= 1'b1;
          skid_ctrl  <= in_ctrl;
          skid_data  <= in_data;
        end else if (con) begin
          main_valid <= 1'b0;
          main_ctrl  <= '0;
        end
      end else begin
        // EMPTY
        if (acc) begin
          main_valid <= 1'b1;
          main_ctrl  <= in_ctrl;
          main_data  <= in_data;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_skid
//  Purpose  : Self-checking bench for pipe_stage_skid. Two instances share
//             the stimulus: one with default parameters, one narrow with
//             CLEAR_DATA=1 and a 3-bit bubble counter. A queue-based
//             reference model predicts both every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [22:0] in_ctrl;
  logic [63:0] in_data;

  logic        in_ready0, out_valid0;
  logic [22:0] out_ctrl0;
  logic [63:0] out_data0;
  logic [1:0]  occ0;
  logic [15:0] cnt0_dut;

  logic        in_ready1, out_valid1;
  logic [7:0]  out_ctrl1;
  logic [15:0] out_data1;
  logic [1:0]  occ1;
  logic [2:0]  cnt1_dut;

  always #5 clk = ~clk;

  pipe_stage_skid dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_ctrl(out_ctrl0), .out_data(out_data0),
    .occupancy(occ0), .bubble_cnt(cnt0_dut)
  );

  pipe_stage_skid #(.CTRL_W(8), .DATA_W(16), .CLEAR_DATA(1'b1), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl[7:0]), .in_data(in_data[15:0]),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_ctrl(out_ctrl1), .out_data(out_data1),
    .occupancy(occ1), .bubble_cnt(cnt1_dut)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [22:0] c;
    logic [63:0] d;
  } ent_t;

  ent_t        q[$];
  logic [63:0] md0 = '0;   // last data shown by the hold-data instance
  logic [63:0] md1 = '0;   // last data shown by the clear-data instance
  int          cnt0 = 0;
  int          cnt1 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_update();
    bit   room;
    ent_t e;
    if (rst) begin
      q.delete();
      md0 = '0; md1 = '0; cnt0 = 0; cnt1 = 0;
    end else begin
      if (out_ready && q.size() == 0) begin
        if (cnt0 < 65535) cnt0++;
        if (cnt1 < 7) cnt1++;
      end
      if (flush) begin
        q.delete();
        md1 = '0;
      end else begin
        room = (q.size() < 2);
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && room) begin
          e.c = in_ctrl; e.d = in_data;
          q.push_back(e);
        end
      end
      if (q.size() > 0) begin
        md0 = q[0].d;
        md1 = q[0].d;
      end
    end
  endtask

  task automatic compare_model();
    logic [22:0] ec;
    ec = (q.size() > 0) ? q[0].c : 23'd0;
    chk("valid0",  64'(out_valid0), 64'(q.size() > 0));
    chk("ready0",  64'(in_ready0),  64'(q.size() < 2));
    chk("occ0",    64'(occ0),       64'(q.size()));
    chk("ctrl0",   64'(out_ctrl0),  64'(ec));
    chk("data0",   out_data0,       md0);
    chk("bcnt0",   64'(cnt0_dut),   64'(cnt0));
    chk("valid1",  64'(out_valid1), 64'(q.size() > 0));
    chk("ready1",  64'(in_ready1),  64'(q.size() < 2));
    chk("occ1",    64'(occ1),       64'(q.size()));
    chk("ctrl1",   64'(out_ctrl1),  64'(ec[7:0]));
    chk("data1",   64'(out_data1),  64'(md1[15:0]));
    chk("bcnt1",   64'(cnt1_dut),   64'(cnt1));
  endtask

  // One clock: model advances on the edge, DUTs sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    compare_model();
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic ordy,
                       input logic [22:0] c, input logic [63:0] d);
    rst = r; flush = f; in_valid = iv; out_ready = ordy; in_ctrl = c; in_data = d;
    cycle();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r, f, iv, ordy;
    logic [22:0] c;
    logic [63:0] d;
    logic        ev;
    logic [1:0]  eocc;
    logic        erdy;
    logic [22:0] ec;
    logic [63:0] ed;
  } vec_t;

  localparam int NV = 19;
  vec_t vt[NV];

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;

    //            r  f  iv or  ctrl        data    ev occ rdy ctrl        data
    vt[0]  = '{1, 0, 0, 0, 23'h0,      64'h0,  0, 0, 1, 23'h0,      64'h0};
    // stream with both sides open
    vt[1]  = '{0, 0, 1, 1, 23'h7FFFFF, 64'h1,  1, 1, 1, 23'h7FFFFF, 64'h1};
    vt[2]  = '{0, 0, 1, 1, 23'h7FFFFF, 64'h2,  1, 1, 1, 23'h7FFFFF, 64'h2};
    vt[3]  = '{0, 0, 1, 1, 23'h7FFFFF, 64'h3,  1, 1, 1, 23'h7FFFFF, 64'h3};
    vt[4]  = '{0, 0, 1, 1, 23'h7FFFFF, 64'h4,  1, 1, 1, 23'h7FFFFF, 64'h4};
    vt[5]  = '{0, 0, 0, 1, 23'h0,      64'h0,  0, 0, 1, 23'h0,      64'h4};
    // backpressure fill, C held upstream, then drain A,B,C
    vt[6]  = '{0, 0, 1, 0, 23'h15,     64'hA,  1, 1, 1, 23'h15,     64'hA};
    vt[7]  = '{0, 0, 1, 0, 23'h2A,     64'hB,  1, 2, 0, 23'h15,     64'hA};
    vt[8]  = '{0, 0, 1, 0, 23'h33,     64'hC,  1, 2, 0, 23'h15,     64'hA};
    vt[9]  = '{0, 0, 1, 1, 23'h33,     64'hC,  1, 1, 1, 23'h2A,     64'hB};
    vt[10] = '{0, 0, 1, 1, 23'h33,     64'hC,  1, 1, 1, 23'h33,     64'hC};
    vt[11] = '{0, 0, 0, 1, 23'h0,      64'h0,  0, 0, 1, 23'h0,      64'hC};
    // flush while full with D offered
    vt[12] = '{0, 0, 1, 0, 23'h11,     64'hA1, 1, 1, 1, 23'h11,     64'hA1};
    vt[13] = '{0, 0, 1, 0, 23'h22,     64'hB1, 1, 2, 0, 23'h11,     64'hA1};
    vt[14] = '{0, 1, 1, 0, 23'h44,     64'hD1, 0, 0, 1, 23'h0,      64'hA1};
    vt[15] = '{0, 0, 0, 0, 23'h0,      64'h0,  0, 0, 1, 23'h0,      64'hA1};
    // simultaneous accept and consume in ONE
    vt[16] = '{0, 0, 1, 0, 23'h55,     64'hE1, 1, 1, 1, 23'h55,     64'hE1};
    vt[17] = '{0, 0, 1, 1, 23'h66,     64'hF1, 1, 1, 1, 23'h66,     64'hF1};
    vt[18] = '{0, 0, 0, 1, 23'h0,      64'h0,  0, 0, 1, 23'h0,      64'hF1};

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].r, vt[i].f, vt[i].iv, vt[i].ordy, vt[i].c, vt[i].d);
      chk($sformatf("vec%0d_valid", i), 64'(out_valid0), 64'(vt[i].ev));
      chk($sformatf("vec%0d_occ", i),   64'(occ0),       64'(vt[i].eocc));
      chk($sformatf("vec%0d_ready", i), 64'(in_ready0),  64'(vt[i].erdy));
      chk($sformatf("vec%0d_ctrl", i),  64'(out_ctrl0),  64'(vt[i].ec));
      chk($sformatf("vec%0d_data", i),  out_data0,       vt[i].ed);
    end

    // ---------------- reset mid-operation, plain and with flush ----------
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 0, 23'h0, 64'h0);
      repeat (5) drive(0, 0, 0, 1, 23'h0, 64'h0);
      drive(0, 0, 1, 0, 23'h1, 64'h100);
      drive(0, 0, 1, 0, 23'h2, 64'h200);
      chk("pre_rst_cnt", 64'(cnt0_dut), 64'd5);
      chk("pre_rst_occ", 64'(occ0),     64'd2);
      drive(1, (k == 1), 1, 1, 23'h3, 64'h300);
      chk("rst_valid", 64'(out_valid0), 64'd0);
      chk("rst_ctrl",  64'(out_ctrl0),  64'd0);
      chk("rst_data",  out_data0,       64'd0);
      chk("rst_occ",   64'(occ0),       64'd0);
      chk("rst_ready", 64'(in_ready0),  64'd1);
      chk("rst_cnt",   64'(cnt0_dut),   64'd0);
    end

    // ---------------- bubble counter and saturation ----------------
    drive(1, 0, 0, 0, 23'h0, 64'h0);
    repeat (10) drive(0, 0, 0, 1, 23'h0, 64'h0);
    chk("bcnt10",      64'(cnt0_dut), 64'd10);
    chk("bcnt_sat_10", 64'(cnt1_dut), 64'd7);
    drive(1, 0, 0, 0, 23'h0, 64'h0);
    repeat (12) drive(0, 0, 0, 1, 23'h0, 64'h0);
    chk("bcnt12",      64'(cnt0_dut), 64'd12);
    chk("bcnt_sat_12", 64'(cnt1_dut), 64'd7);

    // ---------------- randomized traffic against the model ----------------
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 6),
            23'($urandom),
            {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field ID/EX-style stage register.
- Carries a generic control word and data word between two pipeline stages using a valid/ready handshake, not a global stall.
- A 2-entry skid buffer lets upstream ready be registered, so no combinational ready path crosses the stage.
- Supports flush (bubble insertion) and counts bubbles delivered downstream for performance monitoring.
- Instantiated between ID/EX and EX/MEM in the next core revision.

Parameters:
CTRL_W, 23, width of control word (wb/m/exe-style bits); zeroed on every bubble
DATA_W, 64, width of data payload (operands, pc+1, immediates, addresses)
CLEAR_DATA, 0, 1: flush and reset also zero stored data; 0: data registers hold their value on flush
CNT_W, 16, width of the saturating bubble counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
flush  in  1  kill all held and incoming entries this cycle
in_valid  in  1  upstream presents an entry
in_ready  out  1  stage can accept; equals NOT skid_valid (registered)
in_ctrl  in  CTRL_W  upstream control word
in_data  in  DATA_W  upstream data word
out_valid  out  1  main entry valid
out_ready  in  1  downstream accepts
out_ctrl  out  CTRL_W  main entry control; all-zero whenever out_valid=0
out_data  out  DATA_W  main entry data
occupancy  out  2  entries held: 0, 1 or 2
bubble_cnt  out  CNT_W  saturating count of bubble cycles

Behaviour:
- Storage: main {main_valid, main_ctrl, main_data} and skid {skid_valid, skid_ctrl, skid_data}.
- Outputs: out_* come from main. occupancy = main_valid + skid_valid.
- Accept: acc = in_valid & in_ready & ~flush. Consume: con = out_valid & out_ready.
- States and transitions (evaluated only when no rst and no flush):
  - EMPTY (occ 0):
    - acc -> ONE; main <= in. Latency from input to output is 1 cycle.
  - ONE (occ 1):
    - acc & con -> ONE; main <= in.
    - acc & ~con -> FULL; skid <= in; main holds.
    - ~acc & con -> EMPTY.
    - ~acc & ~con -> ONE; main holds.
  - FULL (occ 2; in_ready=0, so acc=0):
    - con -> ONE; main <= skid; skid_valid <= 0.
    - ~con -> FULL; all storage holds.
- Ordering: strict FIFO. The skid entry is always younger than the main entry.
- Bubble control: whenever main_valid becomes 0, main_ctrl is written 0 in the same edge.
  - out_ctrl is therefore all-zero during bubbles, so downstream write-enables are inert.
  - skid_ctrl is likewise zeroed when skid_valid becomes 0.
- Flush (has priority over the handshake, lower priority than rst):
  - Next edge: main_valid=0, skid_valid=0, main_ctrl=0, skid_ctrl=0.
  - The input presented in the flush cycle is discarded.
  - A con in the flush cycle still counts as delivered to downstream.
  - Data is zeroed if CLEAR_DATA=1, otherwise it holds.
  - in_ready is 1 in the cycle after a flush.
- Reset: at any rst edge, mid-operation included:
  - All valids, ctrl and bubble_cnt go to 0. Data goes to 0 regardless of CLEAR_DATA.
  - After reset: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1, bubble_cnt=0.
- bubble_cnt:
  - Increments by 1 on each non-reset edge where out_ready=1 and out_valid=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Not cleared by flush.
- Simultaneous flush & rst: rst wins; the result is identical to reset.
- in_ready depends only on registered state. There is no combinational path from out_ready to in_ready.

Test Plan:
1. Reset then stream:
   - Stimulus: release rst; in_valid=1 and out_ready=1 held; in_data=1,2,3,4 with in_ctrl=0x7FFFFF each.
   - Required: out_data shows 1,2,3,4 on consecutive cycles starting 1 cycle after first accept; in_ready stays 1; occupancy=1.
2. Backpressure fill/drain:
   - Stimulus: out_ready=0 while offering A,B,C.
   - Required: A in main, B in skid; in_ready=0 and occupancy=2 with C held upstream.
   - Stimulus: raise out_ready.
   - Required: outputs A,B,C in order, none lost or duplicated; in_ready returns to 1 the cycle after A is consumed.
3. Flush when FULL:
   - Stimulus: flush=1 for one cycle while occupancy=2 and in_valid=1 with D.
   - Required: next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; D never appears at output.
   - With CLEAR_DATA=0: out_data still equals A.
4. Reset mid-operation:
   - Stimulus: assert rst with occupancy=2 and bubble_cnt=5.
   - Required: next cycle all outputs zero, in_ready=1, bubble_cnt=0; rst together with flush gives the same result.
5. Bubble counter:
   - Stimulus: out_ready=1, in_valid=0 for 10 cycles.
   - Required: bubble_cnt=10.
   - Stimulus: CNT_W=3, 12 idle cycles.
   - Required: bubble_cnt saturates at 7.
6. Simultaneous accept and consume in ONE:
   - Stimulus: main=E; in_valid=1 with F and out_ready=1.
   - Required: next cycle main=F, occupancy=1, skid_valid=0.
